// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Programmable LED blink controller. A prescaler divides CLK_100MHz down to
//   ticks. A DEPTH-entry pattern table holds an LED value and a duration in
//   ticks for each entry. An FSM steps through entries 0..LAST_IDX, either
//   once or in a loop.
//
// State table:
//   IDLE | LEDs off; waiting for START (with STOP low)
//   RUN  | showing table[STEP]; remaining counts ticks left for this entry
//
// Ports:
//   CLK_100MHz  system clock, rising edge
//   RST_N       asynchronous active-low reset; also clears the table
//   WR_EN       table write strobe; writes table[WR_ADDR] <= {WR_LED, WR_DUR}
//   WR_ADDR     table write index
//   WR_LED      LED value for the written entry
//   WR_DUR      duration in ticks for the written entry (0 acts as 1)
//   START       start request, accepted only in IDLE with STOP low
//   STOP        abort; wins over START and over entry expiry
//   LOOP        loop mode, latched at START acceptance
//   LAST_IDX    final entry index, latched at START acceptance
//   LED         registered LED drive
//   BUSY        high while a sequence runs
//   DONE        one-cycle pulse when a one-shot sequence completes
//   STEP        index of the entry currently shown
module led_pattern_sequencer #(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 100000,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int DUR_W    = 16
) (
    input  logic                CLK_100MHz,
    input  logic                RST_N,
    input  logic                WR_EN,
    input  logic [AW-1:0]       WR_ADDR,
    input  logic [NUM_LEDS-1:0] WR_LED,
    input  logic [DUR_W-1:0]    WR_DUR,
    input  logic                START,
    input  logic                STOP,
    input  logic                LOOP,
    input  logic [AW-1:0]       LAST_IDX,
    output logic [NUM_LEDS-1:0] LED,
    output logic                BUSY,
    output logic                DONE,
    output logic [AW-1:0]       STEP
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [NUM_LEDS-1:0] tbl_led [DEPTH];
    logic [DUR_W-1:0]    tbl_dur [DEPTH];
    logic [PW-1:0]       presc;
    logic [DUR_W-1:0]    remaining;
    logic                loop_q;
    logic [AW-1:0]       last_q;

    logic                tick;
    logic                expire;
    logic [AW-1:0]       next_step;

    // A zero duration would otherwise underflow the down-counter; show it
    // for one tick instead.
    function automatic logic [DUR_W-1:0] dur_eff(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign tick      = (presc == TICK_LAST);
    // remaining is never 0 in RUN, so the last tick of an entry is the one
    // seen with remaining==1; the next entry loads on that same edge.
    assign expire    = tick && (remaining == DUR_W'(1));
    assign next_step = STEP + AW'(1);

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_led[i] <= '0;
                tbl_dur[i] <= '0;
            end
        end else if (WR_EN) begin
            tbl_led[WR_ADDR] <= WR_LED;
            tbl_dur[WR_ADDR] <= WR_DUR;
        end
    end

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            LED       <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            STEP      <= '0;
            presc     <= '0;
            remaining <= '0;
            loop_q    <= 1'b0;
            last_q    <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    LED       <= '0;
                    BUSY      <= 1'b0;
                    STEP      <= '0;
                    presc     <= '0;
                    remaining <= '0;
                    if (START && !STOP) begin
                        state     <= RUN;
                        BUSY      <= 1'b1;
                        LED       <= tbl_led[0];
                        remaining <= dur_eff(tbl_dur[0]);
                        loop_q    <= LOOP;
                        last_q    <= LAST_IDX;
                    end
                end
                RUN: begin
                    if (STOP) begin
                        state     <= IDLE;
                        LED       <= '0;
                        BUSY      <= 1'b0;
                        STEP      <= '0;
                        presc     <= '0;
                        remaining <= '0;
                    end else if (expire) begin
                        presc <= '0;
                        if (STEP != last_q) begin
                            STEP      <= next_step;
                            LED       <= tbl_led[next_step];
                            remaining <= dur_eff(tbl_dur[next_step]);
                        end else if (loop_q) begin
                            STEP      <= '0;
                            LED       <= tbl_led[0];
                            remaining <= dur_eff(tbl_dur[0]);
                        end else begin
                            state     <= IDLE;
                            LED       <= '0;
                            BUSY      <= 1'b0;
                            STEP      <= '0;
                            remaining <= '0;
                            DONE      <= 1'b1;
                        end
                    end else if (tick) begin
                        presc     <= '0;
                        remaining <= remaining - DUR_W'(1);
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Testbench for led_pattern_sequencer with TICK_DIV=4. Stimulus pushes the
// expected post-edge outputs into a queue; a monitor pops one entry per
// clock (1 time unit after the rising edge) and compares.
module tb_led_pattern_sequencer;

    localparam int NUM_LEDS = 4;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int DUR_W    = 16;

    typedef struct packed {
        logic [NUM_LEDS-1:0] led;
        logic                busy;
        logic                done;
        logic [AW-1:0]       step;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [NUM_LEDS-1:0] wr_led;
    logic [DUR_W-1:0]    wr_dur;
    logic                start;
    logic                stop;
    logic                loop_mode;
    logic [AW-1:0]       last_idx;
    logic [NUM_LEDS-1:0] led;
    logic                busy;
    logic                done;
    logic [AW-1:0]       step;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   cycle_no;

    led_pattern_sequencer #(
        .NUM_LEDS(NUM_LEDS), .TICK_DIV(TICK_DIV), .DEPTH(DEPTH),
        .AW(AW), .DUR_W(DUR_W)
    ) dut (
        .CLK_100MHz(clk),
        .RST_N     (rst_n),
        .WR_EN     (wr_en),
        .WR_ADDR   (wr_addr),
        .WR_LED    (wr_led),
        .WR_DUR    (wr_dur),
        .START     (start),
        .STOP      (stop),
        .LOOP      (loop_mode),
        .LAST_IDX  (last_idx),
        .LED       (led),
        .BUSY      (busy),
        .DONE      (done),
        .STEP      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string name, input exp_t act, input exp_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got led=%h busy=%b done=%b step=%0d, expected led=%h busy=%b done=%b step=%0d",
                     name, act.led, act.busy, act.done, act.step,
                     exp.led, exp.busy, exp.done, exp.step);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cycle_no++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_vec($sformatf("cycle %0d", cycle_no), {led, busy, done, step}, e);
        end
    end

    // Called at a falling edge with inputs already set; queues the outputs
    // expected after the next rising edge, then clears one-shot inputs.
    task automatic cyc(input logic [3:0] e_led, input logic e_busy,
                       input logic e_done, input logic [2:0] e_step);
        exp_t e;
        e = {e_led, e_busy, e_done, e_step};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic hold(input int n, input logic [3:0] e_led, input logic e_busy,
                        input logic [2:0] e_step);
        for (int i = 0; i < n; i++) cyc(e_led, e_busy, 1'b0, e_step);
    endtask

    task automatic wr_idle(input logic [2:0] a, input logic [3:0] l, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_led = l; wr_dur = d;
        cyc(4'h0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic go(input logic lp, input logic [2:0] last);
        start = 1'b1; loop_mode = lp; last_idx = last;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0; cycle_no = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_led = '0; wr_dur = '0;
        start = 1'b0; stop = 1'b0; loop_mode = 1'b0; last_idx = '0;
        repeat (3) @(negedge clk);
        check_vec("reset", {led, busy, done, step}, {4'h0, 1'b0, 1'b0, 3'd0});
        rst_n = 1'b1;
        cyc(4'h0, 1'b0, 1'b0, 3'd0);
        cyc(4'h0, 1'b0, 1'b0, 3'd0);

        // Empty table: entries 0 and 1 last 4 clocks each, LEDs stay dark.
        go(1'b0, 3'd1);
        hold(4, 4'h0, 1'b1, 3'd0);
        hold(4, 4'h0, 1'b1, 3'd1);
        cyc(4'h0, 1'b0, 1'b1, 3'd0);
        cyc(4'h0, 1'b0, 1'b0, 3'd0);

        // One-shot run.
        wr_idle(3'd0, 4'h1, 16'd2);
        wr_idle(3'd1, 4'h3, 16'd1);
        wr_idle(3'd2, 4'hF, 16'd3);
        go(1'b0, 3'd2);
        hold(8, 4'h1, 1'b1, 3'd0);
        hold(4, 4'h3, 1'b1, 3'd1);
        hold(12, 4'hF, 1'b1, 3'd2);
        cyc(4'h0, 1'b0, 1'b1, 3'd0);
        cyc(4'h0, 1'b0, 1'b0, 3'd0);

        // Loop mode: two full periods, then STOP during entry 1.
        go(1'b1, 3'd2);
        for (int k = 0; k < 2; k++) begin
            hold(8, 4'h1, 1'b1, 3'd0);
            hold(4, 4'h3, 1'b1, 3'd1);
            hold(12, 4'hF, 1'b1, 3'd2);
        end
        hold(8, 4'h1, 1'b1, 3'd0);
        hold(2, 4'h3, 1'b1, 3'd1);
        stop = 1'b1;
        cyc(4'h0, 1'b0, 1'b0, 3'd0);
        cyc(4'h0, 1'b0, 1'b0, 3'd0);

        // Zero duration on entry 1 behaves as one tick.
        wr_idle(3'd1, 4'h3, 16'd0);
        go(1'b0, 3'd2);
        hold(8, 4'h1, 1'b1, 3'd0);
        hold(4, 4'h3, 1'b1, 3'd1);
        hold(12, 4'hF, 1'b1, 3'd2);
        cyc(4'h0, 1'b0, 1'b1, 3'd0);

        // START with STOP in IDLE is refused.
        go(1'b0, 3'd2);
        stop = 1'b1;
        cyc(4'h0, 1'b0, 1'b0, 3'd0);
        cyc(4'h0, 1'b0, 1'b0, 3'd0);

        // STOP on the final expiry edge suppresses DONE.
        go(1'b0, 3'd0);
        hold(7, 4'h1, 1'b1, 3'd0);
        stop = 1'b1;
        cyc(4'h0, 1'b0, 1'b0, 3'd0);
        cyc(4'h0, 1'b0, 1'b0, 3'd0);

        // Live rewrites while entry 0 is displayed.
        go(1'b0, 3'd1);
        cyc(4'h1, 1'b1, 1'b0, 3'd0);
        wr_en = 1'b1; wr_addr = 3'd1; wr_led = 4'hA; wr_dur = 16'd1;
        cyc(4'h1, 1'b1, 1'b0, 3'd0);
        wr_en = 1'b1; wr_addr = 3'd0; wr_led = 4'h5; wr_dur = 16'd3;
        cyc(4'h1, 1'b1, 1'b0, 3'd0);
        hold(5, 4'h1, 1'b1, 3'd0);
        hold(4, 4'hA, 1'b1, 3'd1);
        cyc(4'h0, 1'b0, 1'b1, 3'd0);

        // Rewritten entry 0 takes effect on the next run; then async reset.
        go(1'b1, 3'd2);
        hold(12, 4'h5, 1'b1, 3'd0);
        hold(2, 4'hA, 1'b1, 3'd1);
        #2 rst_n = 1'b0;
        #1 check_vec("async reset", {led, busy, done, step}, {4'h0, 1'b0, 1'b0, 3'd0});
        @(negedge clk);
        rst_n = 1'b1;

        // Table reads back cleared: dark LEDs, 4 clocks per entry.
        go(1'b0, 3'd2);
        hold(4, 4'h0, 1'b1, 3'd0);
        hold(4, 4'h0, 1'b1, 3'd1);
        hold(4, 4'h0, 1'b1, 3'd2);
        cyc(4'h0, 1'b0, 1'b1, 3'd0);
        cyc(4'h0, 1'b0, 1'b0, 3'd0);

        @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left in queue, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Programmable LED blink controller. Replaces the fixed free-running divided-clock LED drive with a sequenced pattern.
- Contains an internal tick prescaler, a DEPTH-entry pattern table (LED value plus duration in ticks) and an FSM.
- The FSM steps through the table once or in a loop under START/STOP control.
- Sits between the board clock and the LED GPIO pins. The table is loaded by host logic or by constant init logic at top level.

Parameters:
- NUM_LEDS, 4, width of LED output and of each table LED field
- TICK_DIV, 100000, clocks per tick (1 ms at 100 MHz); legal range is 2 or more
- DEPTH, 8, number of pattern entries; must be a power of two
- AW, 3, address width = log2(DEPTH)
- DUR_W, 16, width of each entry's duration field, in ticks

Ports:
- CLK_100MHz  in  1  system clock; all logic on its rising edge
- RST_N  in  1  asynchronous active-low reset
- WR_EN  in  1  table write strobe
- WR_ADDR  in  AW  table write index
- WR_LED  in  NUM_LEDS  LED value for the entry
- WR_DUR  in  DUR_W  duration for the entry, in ticks
- START  in  1  start request (level sampled each cycle)
- STOP  in  1  abort request
- LOOP  in  1  loop mode; sampled at START
- LAST_IDX  in  AW  final entry index; sampled at START
- LED  out  NUM_LEDS  registered LED drive
- BUSY  out  1  high while the sequence runs
- DONE  out  1  one-cycle pulse on normal completion
- STEP  out  AW  index of the current entry

Behaviour:
- Reset (RST_N low, asynchronous): LED=0, BUSY=0, DONE=0, STEP=0, prescaler=0, remaining=0, FSM=IDLE, all table entries cleared to 0.
- Table writes:
  - When WR_EN is high, table[WR_ADDR] is written at the clock edge, in any state.
  - An entry already loaded into the run registers is unaffected by a write.
  - A rewritten entry takes effect the next time it is loaded.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in RUN, then wraps.
  - TICK is high for the cycle in which count==TICK_DIV-1.
  - Prescaler is cleared on START acceptance and on every entry load.
- FSM states: IDLE, RUN.
- IDLE:
  - START=1 and STOP=0 is accepted.
  - Next cycle: FSM=RUN, BUSY=1, STEP=0, LED=table[0].led, remaining=max(table[0].dur,1).
  - LOOP and LAST_IDX are latched at acceptance.
  - LED=0 throughout IDLE.
- RUN, on each TICK: remaining decrements. When remaining reaches 0 (entry expiry):
  - STEP!=LAST_IDX: the next edge loads entry STEP+1 (STEP, LED and remaining all update).
  - STEP==LAST_IDX and latched LOOP=1: load entry 0. No DONE pulse; BUSY stays 1.
  - STEP==LAST_IDX and latched LOOP=0: next edge goes to IDLE with LED=0, BUSY=0, STEP=0 and DONE=1 for exactly one cycle.
- Entry timing:
  - Each entry is displayed for exactly max(dur,1)*TICK_DIV clocks.
  - A duration of 0 is treated as 1 tick.
  - No dead cycles between entries.
- STOP:
  - STOP high in RUN: next edge goes to IDLE with LED=0, BUSY=0, STEP=0 and no DONE pulse.
  - STOP has priority over START and over a simultaneous entry expiry.
- START while BUSY is ignored; a sequence must be stopped before it can be restarted.
- A write to an entry during the same cycle that entry is loaded: the loaded value is the old contents; the write lands in the table.
- STEP wraps only via the LOOP path, never by overflow past LAST_IDX.
- RST_N asserted mid-run: immediate return to reset values.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan (all with TICK_DIV=4):
- Reset then idle: check LED=0, BUSY=0, DONE=0, STEP=0. Assert START with nothing written: LED stays 0, each empty entry lasts 4 clocks, DONE pulses after (LAST_IDX+1)*4 clocks.
- One-shot run: load entries 0..2 = (LED 0x1, dur 2), (0x3, dur 1), (0xF, dur 3); LAST_IDX=2, LOOP=0; pulse START.
  - LED=0x1 for 8 clocks, 0x3 for 4 clocks, 0xF for 12 clocks.
  - Then LED=0, BUSY=0, a single DONE pulse, STEP sequence 0,1,2,0.
- Loop mode, same table with LOOP=1: LED sequence repeats with period 24 clocks; DONE never asserts. STOP mid-entry 1: LED=0 and BUSY=0 on the next cycle, no DONE.
- Zero duration and simultaneous events:
  - Entry 1 dur=0: it lasts 4 clocks.
  - START and STOP asserted together in IDLE: stays IDLE.
  - STOP coinciding with the final expiry: no DONE.
- Live rewrite: while entry 0 is displaying, write entry 1 to (0xA, dur 1). Entry 1 then shows 0xA for 4 clocks. Rewriting entry 0 during display does not change the current LED.
- Async reset mid-run: drop RST_N between clock edges. LED, BUSY and STEP clear before the next edge, and the table reads back as cleared on the next run.
